gain_sample_mixer: RTL
======================

Name: gain_sample_mixer

Overview:
- Next-generation time-multiplexed instrument mixer.
- Once per audio frame of SAMPLE_PERIOD clocks it collects at most one sample from each of INSTRUMENT_COUNT instrument streams and applies a per-channel gain and mute.
- Sums into a wide guard-bit accumulator with no intermediate wrap or clipping.
- Emits one saturated SAMPLE_WIDTH-bit mixed sample plus a clip flag to the downstream audio path.

Parameters:
- INSTRUMENT_COUNT, 8, number of input channels (>=2).
- SAMPLE_WIDTH, 16, signed two's-complement width of din and dout.
- GAIN_WIDTH, 8, unsigned gain width; unity = 2^(GAIN_WIDTH-1) (128 at default), max gain just under 2.0.
- SAMPLE_PERIOD, 2272, clocks per output frame; must be >= INSTRUMENT_COUNT+4.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- din  in  SAMPLE_WIDTH x INSTRUMENT_COUNT  per-channel signed sample.
- din_valid  in  1 x INSTRUMENT_COUNT  per-channel sample valid.
- din_ready  out  1 x INSTRUMENT_COUNT  per-channel ready.
- gain  in  GAIN_WIDTH x INSTRUMENT_COUNT  per-channel unsigned gain, sampled at handshake.
- mute  in  INSTRUMENT_COUNT  per-channel mute mask.
- dout  out  SAMPLE_WIDTH  mixed signed sample.
- dout_valid  out  1  one-cycle strobe, dout valid.
- clip  out  1  high with dout_valid when this frame's sum saturated.

Behaviour:
- Reset values:
  - dout=0, dout_valid=0, clip=0, din_ready all 0.
  - Frame counter=0, scan index=0, accumulator=0, pipeline valids=0, consumed flags cleared.
- Counters:
  - Frame counter runs 0..SAMPLE_PERIOD-1 and wraps.
  - Scan index runs 0..INSTRUMENT_COUNT-1 every cycle and wraps; it is not reset per frame.
- Ready:
  - din_ready[i] = (scan==i) & ~consumed[i] & ~mute[i] & (frame counter <= SAMPLE_PERIOD-3) & ~rst. This is combinational from registers and mute.
  - All other channels are 0 in that cycle.
- Handshake: din_valid[i] & din_ready[i] sets consumed[i]. Each channel gives at most one sample per frame.
- Consumed flags clear at the frame wrap edge (counter SAMPLE_PERIOD-1 -> 0).
- Late samples: a channel not valid during the accept window contributes 0 and keeps its sample pending; there is no carry-over of sums.
- Pipeline, from handshake cycle t:
  - Stage 1, edge end of t: product = din*gain as a signed (SAMPLE_WIDTH+GAIN_WIDTH+1)-bit value, arithmetic-shifted right by GAIN_WIDTH-1 (floor toward -inf), registered with a valid bit.
  - Stage 2, edge end of t+1: accumulator += stage-1 value. The accumulator is signed, SAMPLE_WIDTH+clog2(INSTRUMENT_COUNT)+2 bits, and never wraps.
- Frame end, edge ending counter SAMPLE_PERIOD-1:
  - dout <= sat(accumulator); dout_valid <= 1; clip <= (saturated).
  - Accumulator <= 0.
  - dout_valid and clip are therefore visible during counter==0 and return to 0 the next cycle.
- Saturation: sum > 2^(SAMPLE_WIDTH-1)-1 gives 0x7FFF; sum < -2^(SAMPLE_WIDTH-1) gives 0x8000 (default width).
- The accept window closes at SAMPLE_PERIOD-3, so the pipeline is fully drained before the frame-end edge. No accumulator update may coincide with the clear.
- dout holds its value between strobes.
- Mute:
  - A muted channel is never ready and contributes 0.
  - Toggling mute mid-frame affects only future handshakes; an already-accepted sample still counts.
- Gain 0 accepts the sample (consumes it) and contributes 0.
- Reset mid-frame:
  - Discards the in-flight products and the partial sum.
  - No dout_valid is issued for that frame.
  - The first frame after rst falls begins at counter 0, with readies eligible in that same cycle.

Test Plan (INSTRUMENT_COUNT=4, SAMPLE_PERIOD=32, SAMPLE_WIDTH=16, GAIN_WIDTH=8):
- Reset: hold rst 3 cycles with all din_valid=1 -> din_ready all 0, dout=0, dout_valid=0, clip=0. After release, the first dout_valid occurs exactly 32 cycles later.
- Unity mix: gains=128; din=1000, 2000, -500, 0; all valid -> each din_ready handshakes once per frame. dout=2500, clip=0, dout_valid is a single-cycle pulse at counter 0.
- Gain rounding: ch0 gain=64, din=1001 -> dout=500. Next frame din=-1001 -> dout=-501. Gain=255 with din=100 -> 199.
- Saturation: four channels at 0x7000, unity -> dout=0x7FFF, clip=1. Four at 0x9000 -> dout=0x8000, clip=1. Next frame all 0 -> dout=0, clip=0.
- Mute and late valid: ch1 muted with din=5000 -> ch1 never ready and excluded from the sum. ch2 valid first raised at counter 30 -> not accepted this frame, accepted early next frame, and its value appears in the following output.
- Reset mid-frame: two handshakes (300, 400), then rst at counter 10 for 1 cycle -> no dout_valid for the aborted frame. The next frame with ch0=7 only gives dout=7 (no residue).

Source files
------------

// File: rtl/gain_sample_mixer.sv
`default_nettype none
// ============================================================================
// Module  : gain_sample_mixer
// Brief   : Time-multiplexed per-frame instrument mixer with gain, mute,
//           guard-bit accumulation and saturated output.
// Revision: 1.0 - initial release
// ============================================================================
module gain_sample_mixer #(
  parameter int INSTRUMENT_COUNT = 8,
  parameter int SAMPLE_WIDTH     = 16,
  parameter int GAIN_WIDTH       = 8,
  parameter int SAMPLE_PERIOD    = 2272
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [INSTRUMENT_COUNT-1:0][SAMPLE_WIDTH-1:0] din,
  input  logic [INSTRUMENT_COUNT-1:0]                   din_valid,
  output logic [INSTRUMENT_COUNT-1:0]                   din_ready,
  input  logic [INSTRUMENT_COUNT-1:0][GAIN_WIDTH-1:0]   gain,
  input  logic [INSTRUMENT_COUNT-1:0]                   mute,
  output logic [SAMPLE_WIDTH-1:0]                       dout,
  output logic                                         dout_valid,
  output logic                                         clip
);

  localparam int CNT_W  = $clog2(SAMPLE_PERIOD);
  localparam int SCAN_W = $clog2(INSTRUMENT_COUNT);
  localparam int PROD_W = SAMPLE_WIDTH + GAIN_WIDTH + 1;
  localparam int TERM_W = SAMPLE_WIDTH + 2;
  localparam int ACC_W  = SAMPLE_WIDTH + $clog2(INSTRUMENT_COUNT) + 2;

  localparam logic [CNT_W-1:0]        c_cnt_last    = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [CNT_W-1:0]        c_cnt_win_end = CNT_W'(SAMPLE_PERIOD - 3);
  localparam logic [SCAN_W-1:0]       c_scan_last   = SCAN_W'(INSTRUMENT_COUNT - 1);
  localparam logic signed [ACC_W-1:0] c_sat_max =
    {{(ACC_W-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_sat_min =
    {{(ACC_W-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

  logic [CNT_W-1:0]            frame_cnt_q, frame_cnt_d;
  logic [SCAN_W-1:0]           scan_q, scan_d;
  logic [INSTRUMENT_COUNT-1:0] consumed_q, consumed_d;
  logic                        p1_valid_q, p1_valid_d;
  logic signed [TERM_W-1:0]    p1_q, p1_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic [SAMPLE_WIDTH-1:0]     dout_q, dout_d;
  logic                        dout_valid_q, dout_valid_d;
  logic                        clip_q, clip_d;

  logic                        frame_end;
  logic                        in_window;
  logic [INSTRUMENT_COUNT-1:0] hs;
  logic signed [PROD_W-1:0]    prod;
  logic signed [ACC_W-1:0]     term_ext;
  logic                        sat_hi;
  logic                        sat_lo;
  logic [SAMPLE_WIDTH-1:0]     sat_val;

  assign frame_end = (frame_cnt_q == c_cnt_last);
  // Window closes two clocks early so the two-stage pipeline drains before the frame-end clear.
  assign in_window = (frame_cnt_q <= c_cnt_win_end);

  for (genvar i = 0; i < INSTRUMENT_COUNT; i++) begin : g_ready
    assign din_ready[i] = (scan_q == SCAN_W'(i)) & ~consumed_q[i] & ~mute[i] & in_window & ~rst;
  end

  assign hs       = din_valid & din_ready;
  assign prod     = PROD_W'($signed(din[scan_q])) * PROD_W'($signed({1'b0, gain[scan_q]}));
  assign term_ext = ACC_W'(p1_q);

  assign sat_hi  = (acc_q > c_sat_max);
  assign sat_lo  = (acc_q < c_sat_min);
  assign sat_val = sat_hi ? {1'b0, {(SAMPLE_WIDTH-1){1'b1}}} :
                   sat_lo ? {1'b1, {(SAMPLE_WIDTH-1){1'b0}}} :
                            acc_q[SAMPLE_WIDTH-1:0];

  always_comb begin
    frame_cnt_d  = frame_end ? '0 : frame_cnt_q + 1'b1;
    scan_d       = (scan_q == c_scan_last) ? '0 : scan_q + 1'b1;
    consumed_d   = frame_end ? '0 : (consumed_q | hs);
    p1_valid_d   = |hs;
    // Arithmetic shift gives floor rounding toward minus infinity.
    p1_d         = TERM_W'(prod >>> (GAIN_WIDTH - 1));
    acc_d        = acc_q;
    if (frame_end) begin
      acc_d = '0;
    end else if (p1_valid_q) begin
      acc_d = acc_q + term_ext;
    end
    dout_d       = frame_end ? sat_val : dout_q;
    dout_valid_d = frame_end;
    clip_d       = frame_end & (sat_hi | sat_lo);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q  <= '0;
      scan_q       <= '0;
      consumed_q   <= '0;
      p1_valid_q   <= 1'b0;
      p1_q         <= '0;
      acc_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      clip_q       <= 1'b0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      scan_q       <= scan_d;
      consumed_q   <= consumed_d;
      p1_valid_q   <= p1_valid_d;
      p1_q         <= p1_d;
      acc_q        <= acc_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      clip_q       <= clip_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign clip       = clip_q;

endmodule
`default_nettype wire
